// File: rtl/word_tx_pkg.sv
// rtl/word_tx_pkg.sv - shared types and widths for the word-to-byte UART transmit scheduler
package word_tx_pkg;

  localparam int WORD_W      = 16;
  localparam int BYTE_W      = 8;
  localparam int NUM_REQ_DEF = 4;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    GAP_LO,
    SEND_HI,
    GAP_HI
  } state_t;

endpackage

// File: rtl/word_tx_rr_arb.sv
// rtl/word_tx_rr_arb.sv - combinational requester arbiter, round-robin from ptr by default
// WORD_TX_SCHED_FIXED_PRIO_EN selects fixed lowest-index-wins priority and ignores ptr.
module word_tx_rr_arb
  import word_tx_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    grant
);

  logic [MAX_REQ-1:0] valid_pad;

  assign valid_pad = MAX_REQ'(valid);

`ifdef WORD_TX_SCHED_FIXED_PRIO_EN
  logic unused_ptr;

  assign unused_ptr = ^ptr;

  // Scan downward so the lowest asserted index is the last one written.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (valid_pad[k]) begin
        any   = 1'b1;
        grant = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W:0] idx;

  // ptr is always below NUM_REQ, so one conditional subtract wraps the index.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(NUM_REQ)) begin
        idx = idx - (ID_W + 1)'(NUM_REQ);
      end
      if (!any && valid_pad[idx[ID_W-1:0]]) begin
        any   = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/word_tx_sched.sv
// rtl/word_tx_sched.sv - grants one 16-bit requester word at a time and sends it low byte first to UART TX
// WORD_TX_SCHED_FIXED_PRIO_EN selects fixed priority arbitration instead of round-robin.
module word_tx_sched
  import word_tx_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [WORD_W*NUM_REQ-1:0] req_word,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      tx_ready,
  output logic                      tx_dv,
  output logic [BYTE_W-1:0]         tx_byte,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  state_t              state, state_n;
  logic [WORD_W-1:0]   word_q, word_n;
  logic [NUM_REQ-1:0]  ack_n;
  logic                dv_n, busy_n, any;
  logic [BYTE_W-1:0]   byte_n;
  logic [ID_W-1:0]     gid_n, gnt, ptr_q;

`ifdef WORD_TX_SCHED_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [ID_W-1:0] ptr_n;

  assign ptr_n = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (state == IDLE && any) begin
      ptr_q <= ptr_n;
    end
  end
`endif

  word_tx_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .valid(req_valid),
    .ptr  (ptr_q),
    .any  (any),
    .grant(gnt)
  );

  always_comb begin
    state_n = state;
    word_n  = word_q;
    ack_n   = '0;
    dv_n    = 1'b0;
    byte_n  = '0;
    busy_n  = busy;
    gid_n   = grant_id;
    case (state)
      IDLE: begin
        if (any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            ack_n[i] = (gnt == ID_W'(i));
            if (gnt == ID_W'(i)) begin
              word_n = req_word[WORD_W*i +: WORD_W];
            end
          end
          gid_n   = gnt;
          busy_n  = 1'b1;
          state_n = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          dv_n    = 1'b1;
          byte_n  = word_q[BYTE_W-1:0];
          state_n = GAP_LO;
        end
      end
      // The UART needs a cycle to drop ready after a strobe, so ready is not sampled here.
      GAP_LO: state_n = SEND_HI;
      SEND_HI: begin
        if (tx_ready) begin
          dv_n    = 1'b1;
          byte_n  = word_q[WORD_W-1:BYTE_W];
          state_n = GAP_HI;
        end
      end
      GAP_HI: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      word_q   <= '0;
      req_ack  <= '0;
      tx_dv    <= 1'b0;
      tx_byte  <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      state    <= state_n;
      word_q   <= word_n;
      req_ack  <= ack_n;
      tx_dv    <= dv_n;
      tx_byte  <= byte_n;
      busy     <= busy_n;
      grant_id <= gid_n;
    end
  end

endmodule

// File: tb/tb_word_tx_sched.sv
// tb/tb_word_tx_sched.sv - scoreboard bench for word_tx_sched (WORD_TX_SCHED_FIXED_PRIO_EN selects fixed-priority expectations)
module tb_word_tx_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [16*N-1:0] req_word;
  logic [N-1:0]   req_ack;
  logic           tx_ready;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           busy;
  logic [2:0]     grant_id;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   prev_dv = 1'b0;
  int   mon_id;
  logic [7:0] exp_bytes[$];
  int   exp_acks[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_tx_sched #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_word (req_word),
    .req_ack  (req_ack),
    .tx_ready (tx_ready),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .busy     (busy),
    .grant_id (grant_id)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe and ack must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_dv) begin
        check("dv_not_adjacent", int'(prev_dv), 0);
        if (exp_bytes.size() == 0) check("unexpected_tx_dv", int'(tx_byte), -1);
        else check("tx_byte", int'(tx_byte), int'(exp_bytes.pop_front()));
      end else begin
        check("tx_byte_zero_when_idle", int'(tx_byte), 0);
      end
      if (req_ack != '0) begin
        if (exp_acks.size() == 0) begin
          check("unexpected_ack", int'(req_ack), 0);
        end else begin
          mon_id = exp_acks.pop_front();
          check("req_ack", int'(req_ack), 1 << mon_id);
          check("grant_id", int'(grant_id), mon_id);
        end
      end
      prev_dv = tx_dv;
    end
  end

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    tx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_ack(input int i, output int c);
    int n = 0;
    while (!req_ack[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ack_timeout", i, -1);
    c = cyc;
  endtask

  task automatic wait_dv(output int c);
    int n = 0;
    while (!tx_dv && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("tx_dv_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c_ack, c_lo, c_hi, c_rdy, n, n_ack;
    req_word = '0;
    do_reset();

    check("reset_req_ack", int'(req_ack), 0);
    check("reset_tx_dv", int'(tx_dv), 0);
    check("reset_tx_byte", int'(tx_byte), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_grant_id", int'(grant_id), 0);
    mon_en = 1'b1;

    // Single word, ready always high: bytes two cycles apart, busy drops 4 cycles after ack.
    req_word[15:0] = 16'hA55A;
    exp_acks.push_back(0);
    exp_bytes.push_back(8'h5A);
    exp_bytes.push_back(8'hA5);
    req_valid[0] = 1'b1;
    wait_ack(0, c_ack);
    req_valid[0] = 1'b0;
    wait_dv(c_lo);
    check("single_lo_latency", c_lo - c_ack, 1);
    @(negedge clk);
    wait_dv(c_hi);
    check("single_byte_spacing", c_hi - c_lo, 2);
    check("single_busy_before_end", int'(busy), 1);
    @(negedge clk);
    check("single_busy_low_after_4", int'(busy), 0);

    // Backpressure on both bytes.
    do_reset();
    req_word[15:0] = 16'h1234;
    exp_acks.push_back(0);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h12);
    tx_ready = 1'b0;
    req_valid[0] = 1'b1;
    wait_ack(0, c_ack);
    req_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_no_early_dv", int'(tx_dv), 0);
    tx_ready = 1'b1;
    c_rdy = cyc;
    wait_dv(c_lo);
    check("bp_lo_on_first_ready", c_lo - c_rdy, 1);
    tx_ready = 1'b0;
    repeat (4) @(negedge clk);
    tx_ready = 1'b1;
    wait_dv(c_hi);
    check("bp_hi_delayed_3", c_hi - c_lo, 5);
    wait_idle();

`ifdef WORD_TX_SCHED_FIXED_PRIO_EN
    do_reset();
    for (int i = 0; i < N; i++) req_word[16*i +: 16] = 16'h0100 + 16'(i);
    for (int k = 0; k < 3; k++) begin
      exp_acks.push_back(0);
      exp_bytes.push_back(8'h00);
      exp_bytes.push_back(8'h01);
    end
    req_valid = 4'b0101;
    n_ack = 0;
    n = 0;
    while (n_ack < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ack != '0) n_ack++;
    end
    req_valid = '0;
    check("fixed_ack_count", n_ack, 3);
    wait_idle();
`else
    // All requesters valid: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) req_word[16*i +: 16] = 16'h0100 + 16'(i);
    exp_acks = '{0, 1, 2, 3, 0};
    exp_bytes = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h01, 8'h00, 8'h01};
    req_valid = 4'hF;
    n_ack = 0;
    n = 0;
    while (n_ack < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ack != '0) n_ack++;
    end
    req_valid = '0;
    check("rr_ack_count", n_ack, 5);
    wait_idle();
`endif

    // Reset in GAP_LO abandons the word and restarts arbitration from pointer 0.
    do_reset();
    req_word[31:16] = 16'hC3D2;
    req_word[63:48] = 16'h7E81;
    exp_acks.push_back(1);
    exp_bytes.push_back(8'hD2);
    req_valid = 4'b1010;
    wait_ack(1, c_ack);
    req_valid[1] = 1'b0;
    wait_dv(c_lo);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_dv", int'(tx_dv), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_tx_byte", int'(tx_byte), 0);
    check("rst_mid_req_ack", int'(req_ack), 0);
    exp_acks.push_back(1);
    exp_bytes.push_back(8'hD2);
    exp_bytes.push_back(8'hC3);
    exp_acks.push_back(3);
    exp_bytes.push_back(8'h81);
    exp_bytes.push_back(8'h7E);
    req_valid[1] = 1'b1;
    rst = 1'b1;
    wait_ack(1, c_ack);
    req_valid[1] = 1'b0;
    wait_ack(3, c_ack);
    req_valid[3] = 1'b0;
    wait_idle();

    // Requester 1 withdraws before the scheduler returns to IDLE.
    do_reset();
    req_word[15:0]  = 16'h5511;
    req_word[31:16] = 16'hDEAD;
    exp_acks.push_back(0);
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h55);
    req_valid[0] = 1'b1;
    wait_ack(0, c_ack);
    req_valid[0] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (12) @(negedge clk);
    check("withdrawn_idle", int'(busy), 0);

    check("bytes_drained", exp_bytes.size(), 0);
    check("acks_drained", exp_acks.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_tx_sched.md
# word_tx_sched

Scheduler that shares the UART transmit byte path between NUM_REQ word-producing requesters. It grants one pending 16-bit word at a time, serialises it low byte first, then high byte. Each byte is issued only when the UART transmitter reports ready, unlike a free-running word-to-byte split that emits both bytes on back-to-back cycles. It sits between the application word sources and the UART TX core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- req_valid  input  NUM_REQ  per-requester word pending; held until its req_ack
- req_word  input  16*NUM_REQ  requester i word at [16*i+15:16*i]
- req_ack  output  NUM_REQ  one-cycle pulse: word of requester i captured
- tx_ready  input  1  UART TX can accept a byte this cycle
- tx_dv  output  1  one-cycle byte strobe to UART TX
- tx_byte  output  8  byte to send; 0 whenever tx_dv is 0
- busy  output  1  a word is in flight (state not IDLE)
- grant_id  output  3  index of requester currently/last granted

## Operation
- All outputs registered. Reset values: req_ack=0, tx_dv=0, tx_byte=0, busy=0, grant_id=0, state=IDLE, round-robin pointer=0, word register=0.
- FSM states: IDLE, SEND_LO, GAP_LO, SEND_HI, GAP_HI.
- IDLE: if any req_valid, arbitrate winner g, capture req_word[g], pulse req_ack[g], grant_id<=g, busy<=1, go SEND_LO; else stay.
- SEND_LO: wait for tx_ready=1; then tx_dv<=1, tx_byte<=word[7:0], go GAP_LO.
- GAP_LO: one guard cycle, tx_ready ignored (UART needs one cycle to drop ready); go SEND_HI.
- SEND_HI: wait for tx_ready=1; then tx_dv<=1, tx_byte<=word[15:8], go GAP_HI.
- GAP_HI: one guard cycle; busy<=0, go IDLE.
- Arbitration: round-robin; search starts at pointer, pointer <= g+1 modulo NUM_REQ on grant (wraps NUM_REQ-1 -> 0).
- req_valid sampled only in IDLE; a requester deasserting valid before ack is simply not granted, no error.
- req_word changes after ack are ignored; captured word is stable for the whole transfer.
- tx_ready held high continuously: still exactly one guard cycle between bytes.
- Reset mid-transfer: transfer abandoned, no further tx_dv, no ack; requester must re-present.
- grant_id holds last winner after return to IDLE.

## Timing
- Edge E0 (IDLE, valid seen): req_ack high in cycle after E0.
- Earliest tx_dv (low byte) after E1; high byte after E3; back in IDLE after E4; next grant earliest at E5.
- Minimum 5 cycles per word with tx_ready=1; each SEND state extends by the number of cycles tx_ready=0.
- tx_dv pulses never adjacent; at most one tx_dv per two cycles.

## Configuration
- WORD_TX_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins; round-robin pointer not implemented.
- Not defined: round-robin as above (default).

## Structure
- Package word_tx_pkg: state enum (IDLE, SEND_LO, GAP_LO, SEND_HI, GAP_HI), WORD_W=16, BYTE_W=8, NUM_REQ default.
- One sub-module: word_tx_rr_arb (combinational grant from valid vector and pointer, honouring the priority macro).

## Test plan
- Single request: req_valid[0]=1, word 16'hA55A, tx_ready=1 -> req_ack[0] one pulse; tx_dv twice, bytes 8'h5A then 8'hA5, 2 cycles apart; busy low 4 cycles after ack.
- Backpressure: tx_ready=0 for 10 cycles after ack, then 1 -> low byte issued on first ready cycle; tx_ready=0 again 3 cycles before high byte -> high byte delayed 3 cycles; no lost or duplicated strobe.
- Round-robin: all 4 valid continuously, words 16'h0100+i -> grant order 0,1,2,3,0; byte stream 00,01,01,01,02,01,03,01,00,01.
- Fixed priority (macro defined): valids 0 and 2 continuous -> requester 0 granted every time, 2 never.
- Reset mid-transfer: rst=0 in GAP_LO -> next cycle tx_dv=0, busy=0, tx_byte=0; after release the pending requester is re-granted from pointer 0.
- Withdrawn request: req_valid[1] pulsed while busy and dropped before IDLE -> never acked, no bytes sent for it.
